// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor: GROUP-bit CLA slices
// feeding a second-level lookahead, with a valid/ready handshake on both sides.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             blk_g,
    output logic             blk_p
);

    localparam int NG = WIDTH / GROUP;

    logic [WIDTH-1:0] w_bb;
    logic             w_c0;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [NG-1:0]    w_grp_p;
    logic [NG-1:0]    w_grp_g;
    logic             w_in_xfer;
    logic             w_s2_load;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_p;
    logic [WIDTH-1:0] r_s1_g;
    logic [NG-1:0]    r_s1_gp;
    logic [NG-1:0]    r_s1_gg;
    logic             r_s1_c0;

    logic [NG:0]      w_gc;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_blk_g;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_blk_g;
    logic             r_blk_p;

    // Subtraction is a + ~b + ~cin, so cout=1 reads as "no borrow".
    assign w_bb = op ? ~b : b;
    assign w_c0 = op ? ~cin : cin;
    assign w_p  = a ^ w_bb;
    assign w_g  = a & w_bb;

    always_comb begin : p_group_pg
        logic prod;
        prod    = 1'b0;
        w_grp_p = '0;
        w_grp_g = '0;
        for (int k = 0; k < NG; k++) begin
            w_grp_p[k] = &w_p[k*GROUP +: GROUP];
            for (int t = 0; t < GROUP; t++) begin
                prod = w_g[k*GROUP+t];
                for (int m = t + 1; m < GROUP; m++) begin
                    prod = prod & w_p[k*GROUP+m];
                end
                w_grp_g[k] = w_grp_g[k] | prod;
            end
        end
    end

    assign w_s2_load = r_s1_valid & (~r_s2_valid | out_ready);
    assign in_ready  = ~r_s1_valid | w_s2_load;
    assign w_in_xfer = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_s1_p  <= w_p;
            r_s1_g  <= w_g;
            r_s1_gp <= w_grp_p;
            r_s1_gg <= w_grp_g;
            r_s1_c0 <= w_c0;
        end
    end

    // Second-level lookahead, flattened to sum-of-products per group carry.
    always_comb begin : p_group_carry
        logic prod;
        logic acc;
        prod    = 1'b0;
        acc     = 1'b0;
        w_gc    = '0;
        w_blk_g = 1'b0;
        w_gc[0] = r_s1_c0;
        for (int k = 0; k < NG; k++) begin
            acc = r_s1_c0;
            for (int m = 0; m <= k; m++) begin
                acc = acc & r_s1_gp[m];
            end
            for (int j = 0; j <= k; j++) begin
                prod = r_s1_gg[j];
                for (int m = j + 1; m <= k; m++) begin
                    prod = prod & r_s1_gp[m];
                end
                acc = acc | prod;
            end
            w_gc[k+1] = acc;
        end
        for (int j = 0; j < NG; j++) begin
            prod = r_s1_gg[j];
            for (int m = j + 1; m < NG; m++) begin
                prod = prod & r_s1_gp[m];
            end
            w_blk_g = w_blk_g | prod;
        end
    end

    always_comb begin : p_bit_carry
        logic prod;
        logic acc;
        prod = 1'b0;
        acc  = 1'b0;
        w_c  = '0;
        for (int k = 0; k < NG; k++) begin
            for (int t = 0; t < GROUP; t++) begin
                acc = w_gc[k];
                for (int m = 0; m < t; m++) begin
                    acc = acc & r_s1_p[k*GROUP+m];
                end
                for (int j = 0; j < t; j++) begin
                    prod = r_s1_g[k*GROUP+j];
                    for (int m = j + 1; m < t; m++) begin
                        prod = prod & r_s1_p[k*GROUP+m];
                    end
                    acc = acc | prod;
                end
                w_c[k*GROUP+t] = acc;
            end
        end
    end

    assign w_sum = r_s1_p ^ w_c;

    // Result registers only move on a stage-2 load; draining leaves them intact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
            r_blk_g    <= 1'b0;
            r_blk_p    <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_sum      <= w_sum;
            r_cout     <= w_gc[NG];
            r_ovf      <= w_c[WIDTH-1] ^ w_gc[NG];
            r_zero     <= ~|w_sum;
            r_blk_g    <= w_blk_g;
            r_blk_p    <= &r_s1_gp;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign blk_g     = r_blk_g;
    assign blk_p     = r_blk_p;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed-vector and random-scoreboard bench for cla_pipe_adder, covering the
// 16-bit/4-bit default build and a 32-bit/8-bit build.
module tb_cla_pipe_adder;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        op;
        logic [20:0] exp;   // {sum, cout, ovf, zero, blk_g, blk_p}
    } vec_t;

    localparam int NV   = 12;
    localparam int NRND = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, cin, op, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cout, ovf, zero, blk_g, blk_p;

    logic        in_valid2, in_ready2, cin2, op2, out_valid2, out_ready2;
    logic [31:0] a2, b2, sum2;
    logic        cout2, ovf2, zero2, blk_g2, blk_p2;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tbl[NV];
    logic [36:0] q[$];

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .blk_g(blk_g), .blk_p(blk_p)
    );

    cla_pipe_adder #(.WIDTH(32), .GROUP(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .op(op2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2), .blk_g(blk_g2), .blk_p(blk_p2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [36:0] model32(input logic [31:0] ia, input logic [31:0] ib,
                                            input logic ic, input logic io);
        logic [31:0] bb;
        logic        c0;
        logic [32:0] full;
        logic [32:0] gen;
        logic        v;
        bb   = io ? ~ib : ib;
        c0   = io ? ~ic : ic;
        full = {1'b0, ia} + {1'b0, bb} + {32'd0, c0};
        gen  = {1'b0, ia} + {1'b0, bb};
        v    = (ia[31] == bb[31]) && (full[31] != ia[31]);
        return {full[31:0], full[32], v, full[31:0] == 32'd0, gen[32], &(ia ^ bb)};
    endfunction

    initial begin
        int nxt, rx, sent, got;
        logic prev_stall;
        logic [15:0] prev_sum;
        logic pend;

        tbl[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, {16'h5555, 5'b00000}};
        tbl[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 5'b10110}};
        tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 5'b01000}};
        tbl[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 5'b11010}};
        tbl[4]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 5'b00000}};
        tbl[5]  = '{16'h0010, 16'h0003, 1'b1, 1'b1, {16'h000C, 5'b10010}};
        tbl[6]  = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, {16'h0000, 5'b10101}};
        tbl[7]  = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, {16'hFFFF, 5'b00001}};
        tbl[8]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, {16'h0000, 5'b10101}};
        tbl[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, {16'h0000, 5'b11110}};
        tbl[10] = '{16'h0100, 16'h0001, 1'b1, 1'b1, {16'h00FE, 5'b10010}};
        tbl[11] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, {16'h1000, 5'b00000}};

        // Reset held with in_valid asserted.
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; op = 1'b0;
        in_valid2 = 1'b1; out_ready2 = 1'b1; a2 = 32'd7; b2 = 32'd9; cin2 = 1'b0; op2 = 1'b0;
        repeat (3) tick;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_outputs", 64'({sum, cout, ovf, zero, blk_g, blk_p}), 64'd0);
        chk("rst_out_valid32", 64'(out_valid2), 64'd0);
        chk("rst_outputs32", 64'({sum2, cout2, ovf2, zero2, blk_g2, blk_p2}), 64'd0);
        rst_n = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("rst_no_result", 64'(out_valid | out_valid2), 64'd0);
        end

        // Directed table, back-to-back with out_ready high.
        for (int cyc = 0; cyc < NV + 4; cyc++) begin
            out_ready = 1'b1;
            in_valid  = (cyc < NV);
            if (cyc < NV) begin
                a = tbl[cyc].a; b = tbl[cyc].b; cin = tbl[cyc].cin; op = tbl[cyc].op;
            end
            #1;
            if (cyc < NV) chk($sformatf("tbl_in_ready%0d", cyc), 64'(in_ready), 64'd1);
            chk($sformatf("tbl_out_valid%0d", cyc), 64'(out_valid),
                64'(cyc >= 2 && cyc <= NV + 1));
            if (out_valid && cyc >= 2 && cyc - 2 < NV)
                chk($sformatf("vec%0d", cyc - 2),
                    64'({sum, cout, ovf, zero, blk_g, blk_p}), 64'(tbl[cyc-2].exp));
            tick;
        end

        // Backpressure: four adds with the consumer stalled for five cycles.
        nxt = 0; rx = 0; prev_stall = 1'b0; prev_sum = 16'd0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            logic acc, xo;
            out_ready = (cyc >= 5);
            in_valid  = (nxt < 4);
            a = 16'(nxt + 1); b = 16'(nxt + 1); cin = 1'b0; op = 1'b0;
            #1;
            if (nxt == 2 && !out_ready) chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            if (prev_stall) begin
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_sum", 64'(sum), 64'(prev_sum));
            end
            acc = in_valid & in_ready;
            xo  = out_valid & out_ready;
            if (xo) begin
                if (rx < 4) chk($sformatf("bp_sum%0d", rx), 64'(sum), 64'(2 * (rx + 1)));
                else        chk("bp_extra_result", 64'(rx), 64'd3);
                rx++;
            end
            prev_stall = out_valid & ~out_ready;
            prev_sum   = sum;
            tick;
            if (acc) nxt++;
        end
        chk("bp_accepted", 64'(nxt), 64'd4);
        chk("bp_result_count", 64'(rx), 64'd4);

        // Mid-stream reset with two results buffered in each build.
        out_ready = 1'b0; out_ready2 = 1'b0;
        in_valid = 1'b1; a = 16'd5; b = 16'd5; cin = 1'b0; op = 1'b0;
        in_valid2 = 1'b1; a2 = 32'd5; b2 = 32'd5; cin2 = 1'b0; op2 = 1'b0;
        tick;
        a = 16'd6; b = 16'd6; a2 = 32'd6; b2 = 32'd6;
        tick;
        chk("mr_full_in_ready", 64'(in_ready), 64'd0);
        chk("mr_full_in_ready32", 64'(in_ready2), 64'd0);
        in_valid = 1'b0; in_valid2 = 1'b0; rst_n = 1'b0;
        tick;
        chk("mr_dropped", 64'(out_valid | out_valid2), 64'd0);
        chk("mr_in_ready", 64'(in_ready & in_ready2), 64'd1);
        rst_n = 1'b1; out_ready = 1'b1; out_ready2 = 1'b1;
        in_valid = 1'b1; a = 16'd1; b = 16'd1;
        in_valid2 = 1'b1; a2 = 32'd1; b2 = 32'd1;
        tick;
        in_valid = 1'b0; in_valid2 = 1'b0;
        chk("mr_latency_early", 64'(out_valid | out_valid2), 64'd0);
        tick;
        chk("mr_out_valid", 64'(out_valid & out_valid2), 64'd1);
        chk("mr_sum", 64'(sum), 64'd2);
        chk("mr_sum32", 64'(sum2), 64'd2);
        tick;
        chk("mr_drained", 64'(out_valid | out_valid2), 64'd0);
        chk("mr_sum_retained", 64'(sum), 64'd2);
        repeat (2) tick;
        chk("mr_no_stale", 64'(out_valid | out_valid2), 64'd0);

        // 32-bit build: random operands, random backpressure, reference model.
        sent = 0; got = 0; pend = 1'b0;
        for (int cyc = 0; cyc < 1000 && got < NRND; cyc++) begin
            out_ready2 = ($urandom_range(0, 3) != 0);
            if (sent < NRND) begin
                if (!pend) begin
                    a2 = $urandom; b2 = $urandom;
                    cin2 = 1'($urandom_range(0, 1)); op2 = 1'($urandom_range(0, 1));
                    pend = 1'b1;
                end
                in_valid2 = 1'b1;
            end else begin
                in_valid2 = 1'b0;
            end
            #1;
            if (in_valid2 && in_ready2) begin
                q.push_back(model32(a2, b2, cin2, op2));
                sent++;
                pend = 1'b0;
            end
            if (out_valid2 && out_ready2) begin
                if (q.size() == 0) chk("rnd_unexpected", 64'(got), 64'(NRND));
                else chk($sformatf("rnd%0d", got),
                         64'({sum2, cout2, ovf2, zero2, blk_g2, blk_p2}), 64'(q.pop_front()));
                got++;
            end
            tick;
        end
        in_valid2 = 1'b0;
        chk("rnd_result_count", 64'(got), 64'(NRND));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
